// File: rtl/if_stage.sv
// Instruction fetch with writable instruction memory and IF/ID register for the 20-bit pipeline.
// Define IF_BRANCH_EN to honour branch_taken/branch_target; otherwise the PC only increments.
module if_stage #(
  parameter int          IMEM_DEPTH = 16,
  parameter int          PC_W       = 4,
  parameter logic [19:0] NOP_INSTR  = 20'h00000,
  parameter logic [3:0]  HALT_OPC   = 4'hF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stall,
  input  logic            flush,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            imem_we,
  input  logic [PC_W-1:0] imem_waddr,
  input  logic [19:0]     imem_wdata,
  output logic [19:0]     instr_out,
  output logic [PC_W-1:0] pc_out,
  output logic            valid_out,
  output logic            halted
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t          r_state, w_state_next;
  logic [PC_W-1:0] r_pc, w_pc_next;
  logic [19:0]     r_instr, w_instr_next;
  logic [PC_W-1:0] r_pc_out, w_pc_out_next;
  logic            r_valid, w_valid_next;
  logic            r_halt_pend, w_halt_pend_next;
  logic [19:0]     r_mem [IMEM_DEPTH];
  logic [19:0]     w_fetch;
  logic            w_branch;

`ifdef IF_BRANCH_EN
  assign w_branch = branch_taken;
`else
  logic w_unused_branch;
  assign w_branch        = 1'b0;
  assign w_unused_branch = ^{branch_taken, branch_target};
`endif

  // Memory has no reset so its contents survive a pipeline reset.
  always_ff @(posedge clk) begin
    if (imem_we) begin
      r_mem[imem_waddr] <= imem_wdata;
    end
  end

  assign w_fetch = r_mem[r_pc];

  always_comb begin
    w_state_next     = r_state;
    w_pc_next        = r_pc;
    w_instr_next     = r_instr;
    w_pc_out_next    = r_pc_out;
    w_valid_next     = r_valid;
    w_halt_pend_next = 1'b0;
    case (r_state)
      S_RUN: begin
        if (r_halt_pend) begin
          // Halt word sat in IF/ID for one cycle; freeze fetch from now on.
          w_state_next = S_HALT;
          if (flush || !stall) begin
            w_instr_next = NOP_INSTR;
            w_valid_next = 1'b0;
          end
        end else begin
          if (w_branch) begin
            w_pc_next = branch_target;
          end else if (!stall) begin
            w_pc_next = r_pc + PC_W'(1);
          end
          if (flush || w_branch) begin
            w_instr_next = NOP_INSTR;
            w_valid_next = 1'b0;
          end else if (!stall) begin
            w_instr_next     = w_fetch;
            w_pc_out_next    = r_pc;
            w_valid_next     = 1'b1;
            w_halt_pend_next = (w_fetch[19:16] == HALT_OPC);
          end
        end
      end
      default: begin
        if (start) begin
          w_state_next = S_RUN;
          w_pc_next    = '0;
        end
        // Stall holds IF/ID so a halt word stays visible until decode takes it.
        if (flush || !stall) begin
          w_instr_next = NOP_INSTR;
          w_valid_next = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_instr     <= NOP_INSTR;
      r_pc_out    <= '0;
      r_valid     <= 1'b0;
      r_halt_pend <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_pc        <= w_pc_next;
      r_instr     <= w_instr_next;
      r_pc_out    <= w_pc_out_next;
      r_valid     <= w_valid_next;
      r_halt_pend <= w_halt_pend_next;
    end
  end

  assign instr_out = r_instr;
  assign pc_out    = r_pc_out;
  assign valid_out = r_valid;
  assign halted    = (r_state == S_HALT);

endmodule

// File: tb/tb_if_stage.sv
// Randomised scoreboard bench for if_stage against a behavioural fetch model.
module tb_if_stage;
  localparam int DEPTH = 16;
`ifdef IF_BRANCH_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, stall = 1'b0, flush = 1'b0, branch_taken = 1'b0;
  logic [3:0]  branch_target = '0;
  logic        imem_we = 1'b0;
  logic [3:0]  imem_waddr = '0;
  logic [19:0] imem_wdata = '0;
  logic [19:0] instr_out;
  logic [3:0]  pc_out;
  logic        valid_out, halted;

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .instr_out(instr_out), .pc_out(pc_out), .valid_out(valid_out), .halted(halted)
  );

  typedef struct {
    logic [19:0] instr;
    logic [3:0]  pc;
    logic        valid;
    logic        halted;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   txn = 0;

  // Behavioural model: mode 0 idle, 1 fetching, 2 halted.
  int          m_mode = 0;
  int          m_pc = 0;
  logic [19:0] m_mem [DEPTH];
  logic [19:0] m_instr = '0;
  logic [3:0]  m_pc_out = '0;
  bit          m_valid = 0;
  bit          m_halt_seen = 0;

  task automatic check(input string name, input logic [19:0] got, input logic [19:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %05h want %05h (txn %0d)", name, got, want, txn);
    end
  endtask

  task automatic cycle(input bit i_rst, input bit i_start, input bit i_stall, input bit i_flush,
                       input bit i_br, input logic [3:0] i_bt, input bit i_we,
                       input logic [3:0] i_wa, input logic [19:0] i_wd);
    exp_t        e;
    logic [19:0] word;
    bit          loaded_halt;
    @(negedge clk);
    start = i_start; stall = i_stall; flush = i_flush;
    branch_taken = i_br; branch_target = i_bt;
    imem_we = i_we; imem_waddr = i_wa; imem_wdata = i_wd;
    loaded_halt = 0;
    if (i_rst) begin
      rst = 1'b1;
      #1;
      check("rst_instr", instr_out, 20'h00000);
      check("rst_pc", {16'h0, pc_out}, 20'h0);
      check("rst_valid", {19'h0, valid_out}, 20'h0);
      check("rst_halted", {19'h0, halted}, 20'h0);
      m_mode = 0; m_pc = 0; m_instr = '0; m_pc_out = '0; m_valid = 0; m_halt_seen = 0;
    end else begin
      rst = 1'b0;
      word = m_mem[m_pc];
      if (m_mode == 1 && m_halt_seen) begin
        m_mode = 2;
        if (i_flush || !i_stall) begin m_instr = '0; m_valid = 0; end
      end else if (m_mode == 1) begin
        if (i_flush || (BR_EN && i_br)) begin
          m_instr = '0; m_valid = 0;
        end else if (!i_stall) begin
          m_instr = word; m_pc_out = 4'(m_pc); m_valid = 1;
          loaded_halt = (word[19:16] == 4'hF);
        end
        if (BR_EN && i_br) m_pc = int'(i_bt);
        else if (!i_stall) m_pc = (m_pc + 1) % DEPTH;
      end else begin
        if (i_start) begin m_mode = 1; m_pc = 0; end
        if (i_flush || !i_stall) begin m_instr = '0; m_valid = 0; end
      end
      m_halt_seen = loaded_halt;
    end
    if (i_we) m_mem[i_wa] = i_wd;
    e.instr = m_instr; e.pc = m_pc_out; e.valid = m_valid; e.halted = (m_mode == 2);
    sb_q.push_back(e);
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 4'h0, 0, 4'h0, 20'h0);
  endtask

  task automatic write_word(input logic [3:0] a, input logic [19:0] d);
    cycle(0, 0, 0, 0, 0, 4'h0, 1, a, d);
  endtask

  // Monitor: one expected entry per clock edge after stimulus starts.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        txn++;
        $display("txn %0d instr=%05h pc=%0d valid=%0b halted=%0b", txn, instr_out, pc_out, valid_out, halted);
        check("instr", instr_out, e.instr);
        check("pc_out", {16'h0, pc_out}, {16'h0, e.pc});
        check("valid", {19'h0, valid_out}, {19'h0, e.valid});
        check("halted", {19'h0, halted}, {19'h0, e.halted});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] w;
    cycle(1, 0, 0, 0, 0, 4'h0, 0, 4'h0, 20'h0);
    // Fill memory: test-plan words at 0..3, a marker at 10, no HALT opcodes elsewhere.
    for (int i = 0; i < DEPTH; i++) begin
      case (i)
        0: w = 20'h1_0203;
        1: w = 20'h2_0405;
        2: w = 20'h3_0607;
        3: w = 20'h4_0809;
        10: w = 20'hA_0A0A;
        default: w = {4'($urandom_range(0, 14)), 16'($urandom)};
      endcase
      write_word(4'(i), w);
    end
    // Start, stream, stall twice on word 1, then branch to 10 with PC at 3.
    cycle(0, 1, 0, 0, 0, 4'h0, 0, 4'h0, 20'h0);
    idle_cycles(2);
    cycle(0, 0, 1, 0, 0, 4'h0, 0, 4'h0, 20'h0);
    cycle(0, 0, 1, 0, 0, 4'h0, 0, 4'h0, 20'h0);
    idle_cycles(1);
    cycle(0, 0, 0, 0, 1, 4'hA, 0, 4'h0, 20'h0);
    idle_cycles(3);
    // Halt at mem[2]: frozen PC, stall holds, then restart from 0.
    cycle(1, 0, 0, 0, 0, 4'h0, 0, 4'h0, 20'h0);
    write_word(4'h2, 20'hF_0000);
    cycle(0, 1, 0, 0, 0, 4'h0, 0, 4'h0, 20'h0);
    idle_cycles(6);
    cycle(0, 0, 1, 0, 0, 4'h0, 0, 4'h0, 20'h0);
    cycle(0, 1, 0, 0, 0, 4'h0, 0, 4'h0, 20'h0);
    idle_cycles(4);
    // Flushed halt word must not halt: flush the edge that would load mem[2].
    cycle(1, 0, 0, 0, 0, 4'h0, 0, 4'h0, 20'h0);
    cycle(0, 1, 0, 0, 0, 4'h0, 0, 4'h0, 20'h0);
    idle_cycles(2);
    cycle(0, 0, 0, 1, 0, 4'h0, 0, 4'h0, 20'h0);
    idle_cycles(3);
    // Wrap from PC 15 to 0.
    cycle(1, 0, 0, 0, 0, 4'h0, 1, 4'h2, 20'h3_0607);
    cycle(0, 1, 0, 0, 0, 4'h0, 0, 4'h0, 20'h0);
    idle_cycles(20);
    // Reset during a stall, then memory must still hold the test words.
    cycle(0, 0, 1, 0, 0, 4'h0, 0, 4'h0, 20'h0);
    cycle(1, 0, 1, 0, 0, 4'h0, 0, 4'h0, 20'h0);
    cycle(0, 1, 0, 0, 0, 4'h0, 0, 4'h0, 20'h0);
    idle_cycles(5);
    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom % 64) == 0, ($urandom % 8) == 0, ($urandom % 4) == 0,
            ($urandom % 10) == 0, ($urandom % 10) == 0, 4'($urandom),
            ($urandom % 5) == 0, 4'($urandom), 20'($urandom));
    end
    idle_cycles(2);
    @(posedge clk);
    #3;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending want 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
